// File: rtl/operand_serializer.sv
// Operand serializer: latches an operand pair plus carry-in and emits both operands LSB first.
// Latency: bit 0 appears the cycle after acceptance, done pulses one cycle after bit WIDTH-1.
// Backpressure: in_ready is high only while idle; offers made at any other time are ignored.
module operand_serializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin_in,
   output logic             a_out,
   output logic             b_out,
   output logic             cin_out,
   output logic             bit_valid,
   output logic             first_bit,
   output logic             last_bit,
   output logic             done
);

   // one extra bit so the counter can represent WIDTH-1 for every legal WIDTH, including 1
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sh_a, sh_b, sh_a_nxt, sh_b_nxt;
   logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
   logic             cin_nxt, a_nxt, b_nxt, valid_nxt, first_nxt, last_nxt, done_nxt, ready_nxt;

   // next-state and next-output logic; outputs are computed one cycle ahead so they can be registered
   always_comb begin
      state_nxt = state;
      sh_a_nxt  = sh_a;
      sh_b_nxt  = sh_b;
      cnt_nxt   = cnt;
      cnt_inc   = cnt + CW'(1);
      cin_nxt   = cin_out;
      a_nxt     = 1'b0;
      b_nxt     = 1'b0;
      valid_nxt = 1'b0;
      first_nxt = 1'b0;
      last_nxt  = 1'b0;
      done_nxt  = 1'b0;
      ready_nxt = 1'b0;
      case (state)
         IDLE: begin
            ready_nxt = 1'b1;
            if (in_valid) begin
               sh_a_nxt  = op_a;
               sh_b_nxt  = op_b;
               cnt_nxt   = '0;
               cin_nxt   = cin_in;
               state_nxt = SHIFT;
               ready_nxt = 1'b0;
               a_nxt     = op_a[0];
               b_nxt     = op_b[0];
               valid_nxt = 1'b1;
               first_nxt = 1'b1;
               last_nxt  = (LAST == '0);
            end
         end
         SHIFT: begin
            sh_a_nxt = sh_a >> 1;
            sh_b_nxt = sh_b >> 1;
            cnt_nxt  = cnt_inc;
            if (cnt == LAST) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end else begin
               // after the shift, bit 0 of the register is bit cnt+1 of the original operand
               a_nxt     = sh_a_nxt[0];
               b_nxt     = sh_b_nxt[0];
               valid_nxt = 1'b1;
               last_nxt  = (cnt_inc == LAST);
            end
         end
         DONE: begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
         end
      endcase
   end

   // state, datapath and registered outputs; reset abandons any word in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         sh_a      <= '0;
         sh_b      <= '0;
         cnt       <= '0;
         cin_out   <= 1'b0;
         a_out     <= 1'b0;
         b_out     <= 1'b0;
         bit_valid <= 1'b0;
         first_bit <= 1'b0;
         last_bit  <= 1'b0;
         done      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= state_nxt;
         sh_a      <= sh_a_nxt;
         sh_b      <= sh_b_nxt;
         cnt       <= cnt_nxt;
         cin_out   <= cin_nxt;
         a_out     <= a_nxt;
         b_out     <= b_nxt;
         bit_valid <= valid_nxt;
         first_bit <= first_nxt;
         last_bit  <= last_nxt;
         done      <= done_nxt;
         in_ready  <= ready_nxt;
      end
   end

endmodule

// File: tb/tb_operand_serializer.sv
// Bench for operand_serializer: WIDTH=8 and WIDTH=1 instances against a per-cycle reference model.
// Each observation is the output vector {a,b,cin,bit_valid,first,last,done,in_ready}.
// Inputs change just after rising edges; outputs are sampled on falling edges.
module tb_operand_serializer;

   localparam int W = 8;
   localparam int P = W + 2;   // spacing between back-to-back words

   logic         clk;
   logic         reset;
   logic         in_valid, in_valid1;
   logic [W-1:0] op_a, op_b;
   logic [0:0]   a1, b1;
   logic         cin_in, cin1;
   logic         in_ready, a_out, b_out, cin_out, bit_valid, first_bit, last_bit, done;
   logic         in_ready1, a_out1, b_out1, cin_out1, bit_valid1, first_bit1, last_bit1, done1;

   int tests = 0;
   int fails = 0;

   operand_serializer #(.WIDTH(W)) u8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .cin_in(cin_in),
      .a_out(a_out), .b_out(b_out), .cin_out(cin_out), .bit_valid(bit_valid),
      .first_bit(first_bit), .last_bit(last_bit), .done(done)
   );

   operand_serializer #(.WIDTH(1)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
      .op_a(a1), .op_b(b1), .cin_in(cin1),
      .a_out(a_out1), .b_out(b_out1), .cin_out(cin_out1), .bit_valid(bit_valid1),
      .first_bit(first_bit1), .last_bit(last_bit1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] obs8();
      return {a_out, b_out, cin_out, bit_valid, first_bit, last_bit, done, in_ready};
   endfunction

   function automatic logic [7:0] obs1();
      return {a_out1, b_out1, cin_out1, bit_valid1, first_bit1, last_bit1, done1, in_ready1};
   endfunction

   // Reference: t cycles after the accepting edge, a w-bit word shows bit t-1 for t=1..w,
   // done at t=w+1, then idle with in_ready; cin is held throughout.
   function automatic logic [7:0] exp_vec(int w, int t, logic [31:0] a, logic [31:0] b, logic c);
      if (t >= 1 && t <= w)
         return {a[t-1], b[t-1], c, 1'b1, (t == 1), (t == w), 1'b0, 1'b0};
      else if (t == w + 1)
         return {1'b0, 1'b0, c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      else
         return {1'b0, 1'b0, c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // offer one word to the WIDTH=8 instance (called right after a falling edge while idle),
   // then scramble the inputs and check ncheck subsequent cycles
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c, input int ncheck);
      in_valid = 1'b1; op_a = a; op_b = b; cin_in = c;
      @(posedge clk); #1;
      in_valid = 1'($urandom); op_a = 8'($urandom); op_b = 8'($urandom); cin_in = 1'($urandom);
      for (int t = 1; t <= ncheck; t++) begin
         @(negedge clk);
         if (t == 1) in_valid = 1'b0;
         chk($sformatf("w8 a=%h b=%h t=%0d", a, b, t), obs8(), exp_vec(W, t, {24'b0, a}, {24'b0, b}, c));
      end
      in_valid = 1'b0;
   endtask

   task automatic send1(input logic a, input logic b, input logic c);
      in_valid1 = 1'b1; a1 = a; b1 = b; cin1 = c;
      @(posedge clk); #1;
      in_valid1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      for (int t = 1; t <= 3; t++) begin
         @(negedge clk);
         chk($sformatf("w1 a=%b b=%b t=%0d", a, b, t), obs1(), exp_vec(1, t, {31'b0, a}, {31'b0, b}, c));
      end
   endtask

   logic [7:0] ha [3*P];
   logic [7:0] hb [3*P];
   logic       hc [3*P];
   int         base;

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_valid1 = 1'b0;
      op_a = '0; op_b = '0; cin_in = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      #3;
      chk("reset w8", obs8(), 8'b0000_0001);
      chk("reset w1", obs1(), 8'b0000_0001);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("idle after reset", obs8(), 8'b0000_0001);

      // directed word, then random words, each checked through done and back to idle
      send8(8'hA5, 8'h3C, 1'b1, W + 2);
      for (int i = 0; i < 6; i++)
         send8(8'($urandom), 8'($urandom), 1'($urandom), W + 2);
      send8(8'h00, 8'hFF, 1'b0, W + 2);

      // in_valid held high with operands changing every cycle: only every P-th edge accepts
      for (int e = 0; e < 3*P; e++) begin
         ha[e] = 8'($urandom); hb[e] = 8'($urandom); hc[e] = 1'($urandom);
      end
      for (int e = 0; e < 3*P; e++) begin
         in_valid = 1'b1; op_a = ha[e]; op_b = hb[e]; cin_in = hc[e];
         @(posedge clk); #1;
         if (e == 3*P - 1) in_valid = 1'b0;
         @(negedge clk);
         base = (e / P) * P;
         chk($sformatf("b2b cycle=%0d", e + 1), obs8(),
             exp_vec(W, e + 1 - base, {24'b0, ha[base]}, {24'b0, hb[base]}, hc[base]));
      end
      @(negedge clk);
      chk("b2b idle", obs8(), exp_vec(W, P, 32'b0, 32'b0, hc[2*P]));

      // reset mid-word (bit 4 on the outputs): immediate clear, no done, then a clean word
      send8(8'hFF, 8'hFF, 1'b1, 5);
      #2 reset = 1'b1;
      #1 chk("async reset w8", obs8(), 8'b0000_0001);
      @(negedge clk);
      chk("held reset w8", obs8(), 8'b0000_0001);
      reset = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         chk($sformatf("no done after reset %0d", i), obs8(), 8'b0000_0001);
      end
      send8(8'h01, 8'h00, 1'b0, W + 2);

      // WIDTH=1: first and last in the same cycle
      send1(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++)
         send1(1'($urandom), 1'($urandom), 1'($urandom));
      send1(1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/operand_serializer.md
OPERAND_SERIALIZER -- requirements
Module: operand_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning an operand pair is offered.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept an operand pair.
REQ-006 SHALL have port op_a, input, WIDTH, the first operand.
REQ-007 SHALL have port op_b, input, WIDTH, the second operand.
REQ-008 SHALL have port cin_in, input, 1, the carry-in for the word.
REQ-009 SHALL have port a_out, output, 1, the current serial bit of op_a (LSB first).
REQ-010 SHALL have port b_out, output, 1, the current serial bit of op_b (LSB first).
REQ-011 SHALL have port cin_out, output, 1, the latched carry-in, held for the whole word.
REQ-012 SHALL have port bit_valid, output, 1, meaning a_out and b_out carry a valid bit this cycle.
REQ-013 SHALL have port first_bit, output, 1, meaning the current bit is bit 0.
REQ-014 SHALL have port last_bit, output, 1, meaning the current bit is bit WIDTH-1.
REQ-015 SHALL have port done, output, 1, a one-cycle pulse after the last bit.

Function
REQ-016 SHALL implement an FSM with states IDLE, SHIFT and DONE; all outputs SHALL be registered.
REQ-017 SHALL assert in_ready only in IDLE.
REQ-018 On an edge with in_valid=1 and in_ready=1, SHALL latch op_a, op_b and cin_in into shift registers and cin_out, clear the bit counter, and enter SHIFT.
REQ-019 SHALL ignore in_valid while in SHIFT or DONE; operands offered then are not latched.
REQ-020 In SHIFT, SHALL drive a_out/b_out with bit[cnt] of the latched operands, with bit_valid=1.
REQ-021 In SHIFT, SHALL assert first_bit when cnt=0 and last_bit when cnt=WIDTH-1.
REQ-022 In SHIFT, SHALL shift both registers right by one and increment cnt on each edge.
REQ-023 SHALL use cnt of width clog2(WIDTH)+1 so that it never wraps before WIDTH-1.
REQ-024 After the edge on which cnt=WIDTH-1, SHALL enter DONE.
REQ-025 In DONE, SHALL hold done=1 for exactly one cycle with bit_valid=0, then return to IDLE.
REQ-026 Latency: accept at edge k; bit 0 is visible in cycle k+1; bit WIDTH-1 is visible in cycle k+WIDTH; done is high in cycle k+WIDTH+1; in_ready is high again in cycle k+WIDTH+2.
REQ-027 With WIDTH=1, SHALL assert first_bit and last_bit in the same single SHIFT cycle.
REQ-028 Outside SHIFT, SHALL force a_out, b_out, first_bit, last_bit and bit_valid to 0.
REQ-029 cin_out SHALL keep its value until the next accepted word.

Reset
REQ-030 reset=1 SHALL immediately force IDLE, cnt=0, shift registers=0, a_out=b_out=cin_out=bit_valid=first_bit=last_bit=done=0 and in_ready=1, regardless of the clock.
REQ-031 A reset asserted during SHIFT SHALL abandon the word with no done pulse; the first edge after reset release SHALL be able to accept a new word.

Verification
REQ-032 WIDTH=8, reset, then op_a=0xA5, op_b=0x3C, cin_in=1, in_valid for 1 cycle -> a_out=1,0,1,0,0,1,0,1; b_out=0,0,1,1,1,1,0,0 over 8 cycles with bit_valid=1 and cin_out=1; done pulses once in cycle 9.
REQ-033 Same word as REQ-032 -> first_bit high only in cycle 1 and last_bit high only in cycle 8; in_ready is low from cycle 1 through cycle 9 and high in cycle 10.
REQ-034 in_valid held high continuously with op_a changing every cycle -> only the values present at the in_ready=1 edges are serialized; back-to-back words are spaced WIDTH+2 cycles apart.
REQ-035 Reset pulse at cnt=4 of 0xFF/0xFF -> outputs go to 0 asynchronously, no done pulse; the next word 0x01/0x00, cin_in=0 serializes correctly.
REQ-036 WIDTH=1 with op_a=1, op_b=1 -> a single cycle with a_out=b_out=first_bit=last_bit=bit_valid=1, then done=1.
